// File: rtl/mem_port_arbiter_pkg.sv
// Shared word size and arbiter FSM encodings for the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned WORD_SIZE = 16;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDread  = 3'd2;
    localparam logic [2:0] StDwrite = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    function automatic logic is_read_state(input logic [2:0] st);
        return (st == StFetch) || (st == StDread);
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Wait-cycle counter for a bus transaction; flags expiry on the last allowed waiting cycle.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // The edge ending the TIMEOUT_CYCLES-th waiting cycle is the abort edge.
    assign expired = enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one memory bus, data port first, with timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fetch_req,
    input  logic [WORD_SIZE-1:0] fetch_addr,
    output logic [WORD_SIZE-1:0] fetch_data,
    output logic                 fetch_done,
    input  logic                 dmem_req,
    input  logic                 dmem_we,
    input  logic [WORD_SIZE-1:0] dmem_addr,
    input  logic [WORD_SIZE-1:0] dmem_wdata,
    output logic [WORD_SIZE-1:0] dmem_rdata,
    output logic                 dmem_done,
    output logic                 bus_err,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput
);

    logic [2:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, wdata_q, fetch_data_q, dmem_rdata_q;
    logic                 is_data_q, bus_err_q;
    logic                 grant, waiting, response, wd_expired;

    assign grant    = (state_q == StIdle) && (dmem_req || fetch_req);
    assign waiting  = is_read_state(state_q) || (state_q == StDwrite);
    // Only the handshake matching the current direction counts as a response.
    assign response = (is_read_state(state_q) && inputReady) ||
                      ((state_q == StDwrite) && ackOutput);

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (grant),
        .enable (waiting && !response),
        .expired(wd_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (dmem_req) begin
                    state_d = dmem_we ? StDwrite : StDread;
                end else if (fetch_req) begin
                    state_d = StFetch;
                end
            end
            StFetch, StDread, StDwrite: begin
                if (response) begin
                    state_d = StDone;
                end else if (wd_expired) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            is_data_q    <= 1'b0;
            fetch_data_q <= '0;
            dmem_rdata_q <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= wd_expired;
            if (grant) begin
                addr_q    <= dmem_req ? dmem_addr : fetch_addr;
                wdata_q   <= dmem_wdata;
                is_data_q <= dmem_req;
            end
            if (is_read_state(state_q) && inputReady) begin
                if (state_q == StFetch) begin
                    fetch_data_q <= data;
                end else begin
                    dmem_rdata_q <= data;
                end
            end
        end
    end

    assign readM      = is_read_state(state_q);
    assign writeM     = (state_q == StDwrite);
    assign address    = addr_q;
    assign data       = writeM ? wdata_q : {WORD_SIZE{1'bz}};
    assign fetch_data = fetch_data_q;
    assign dmem_rdata = dmem_rdata_q;
    assign fetch_done = (state_q == StDone) && !is_data_q;
    assign dmem_done  = (state_q == StDone) && is_data_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned T = 15;
    localparam logic [15:0] PROBE = 16'h5A3C;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_req = 1'b0, dmem_req = 1'b0, dmem_we = 1'b0;
    logic [15:0] fetch_addr = '0, dmem_addr = '0, dmem_wdata = '0;
    logic [15:0] fetch_data, dmem_rdata, address;
    logic        fetch_done, dmem_done, bus_err, readM, writeM;
    logic        inputReady = 1'b0, ackOutput = 1'b0;
    logic        tb_drv_en = 1'b1;
    logic [15:0] tb_drv_val = PROBE;
    wire  [15:0] data;

    // Memory side of the bus; PROBE while idle exposes any stray DUT drive.
    assign data = tb_drv_en ? tb_drv_val : 16'hzzzz;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_fetch_data = '0;
    logic [15:0] exp_dmem_rdata = '0;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .fetch_req (fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_data(fetch_data),
        .fetch_done(fetch_done),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_done (dmem_done),
        .bus_err   (bus_err),
        .readM     (readM),
        .writeM    (writeM),
        .address   (address),
        .data      (data),
        .inputReady(inputReady),
        .ackOutput (ackOutput)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, got, exp);
        end
    endtask

    // Starts at the negedge of an IDLE cycle; lat = waiting cycle on which memory responds.
    task automatic run_txn(input bit is_dmem, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rdata,
                           input int lat, input bit keep_fetch);
        bit is_read;
        bit ok;
        int n;
        is_read = !is_dmem || !we;
        ok      = (lat <= int'(T));
        n       = ok ? lat : int'(T);
        tb_drv_en  = is_read;
        tb_drv_val = PROBE;
        if (is_dmem) begin
            dmem_req = 1'b1; dmem_we = we; dmem_addr = addr; dmem_wdata = wdata;
            if (keep_fetch) fetch_req = 1'b1;
        end else begin
            fetch_req = 1'b1; fetch_addr = addr;
        end
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            inputReady = 1'b0; ackOutput = 1'b0; tb_drv_val = PROBE;
            if (k == 1) begin
                // Request-side changes after grant must have no effect.
                if (is_dmem) begin
                    dmem_we = 1'($urandom); dmem_addr = 16'($urandom);
                    dmem_wdata = 16'($urandom);
                end else begin
                    fetch_addr = 16'($urandom);
                end
            end
            #1;
            check("wait_readM", readM, is_read);
            check("wait_writeM", writeM, !is_read);
            check("wait_address", address, addr);
            check("wait_data_bus", data, is_read ? PROBE : wdata);
            check("wait_no_pulse", {fetch_done, dmem_done, bus_err}, 3'b000);
            if (ok && k == lat) begin
                if (is_read) begin
                    inputReady = 1'b1; tb_drv_val = rdata;
                end else begin
                    ackOutput = 1'b1;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                if (is_read) ackOutput = 1'b1;
                else inputReady = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        inputReady = 1'b0; ackOutput = 1'b0;
        tb_drv_en = 1'b1; tb_drv_val = PROBE;
        if (ok && is_read) begin
            if (is_dmem) exp_dmem_rdata = rdata;
            else exp_fetch_data = rdata;
        end
        #1;
        check("end_fetch_done", fetch_done, ok && !is_dmem);
        check("end_dmem_done", dmem_done, ok && is_dmem);
        check("end_bus_err", bus_err, !ok);
        check("end_strobes", {readM, writeM}, 2'b00);
        check("end_data_released", data, PROBE);
        check("fetch_data", fetch_data, exp_fetch_data);
        check("dmem_rdata", dmem_rdata, exp_dmem_rdata);
        dmem_req = 1'b0;
        if (!keep_fetch) fetch_req = 1'b0;
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("idle_quiet", {readM, writeM, fetch_done, dmem_done, bus_err}, 5'b0);
        end
    endtask

    initial begin
        int mode, lat, lat2, r;
        #1;
        check("rst_strobes", {readM, writeM}, 2'b00);
        check("rst_address", address, 16'h0000);
        check("rst_data_released", data, PROBE);
        check("rst_fetch_data", fetch_data, 16'h0000);
        check("rst_dmem_rdata", dmem_rdata, 16'h0000);
        check("rst_pulses", {fetch_done, dmem_done, bus_err}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h6A01, 3, 1'b0);
        run_txn(1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h0000, 2, 1'b0);
        fetch_addr = 16'h0030;
        run_txn(1'b1, 1'b0, 16'h0041, 16'h0000, 16'hC0DE, 2, 1'b1);
        run_txn(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h1357, 1, 1'b0);
        run_txn(1'b0, 1'b0, 16'h0020, 16'h0000, 16'hDEAD, int'(T) + 1, 1'b0);
        run_txn(1'b1, 1'b0, 16'h0022, 16'h0000, 16'h2468, int'(T), 1'b0);
        run_txn(1'b1, 1'b1, 16'h0023, 16'h7777, 16'h0000, int'(T) + 2, 1'b0);

        // Reset pulse in the middle of a write.
        tb_drv_en = 1'b0;
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 16'h0050; dmem_wdata = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_writeM", writeM, 1'b1);
        check("pre_rst_data", data, 16'h1234);
        #1;
        reset_n = 1'b0;
        tb_drv_en = 1'b1;
        dmem_req = 1'b0;
        exp_fetch_data = '0;
        exp_dmem_rdata = '0;
        #1;
        check("mid_rst_writeM", writeM, 1'b0);
        check("mid_rst_data_released", data, PROBE);
        check("mid_rst_address", address, 16'h0000);
        check("mid_rst_rdata", {fetch_data, dmem_rdata}, 32'h0);
        #9;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_quiet", {readM, writeM, fetch_done, dmem_done, bus_err}, 5'b0);
        end

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            r    = $urandom_range(0, 9);
            lat  = (r == 0) ? int'(T) : (r == 1) ? int'(T) + 1 + $urandom_range(0, 2)
                                                  : $urandom_range(1, 6);
            lat2 = $urandom_range(1, 5);
            case (mode)
                0: run_txn(1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), lat, 1'b0);
                1: run_txn(1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), lat, 1'b0);
                2: run_txn(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), lat, 1'b0);
                default: begin
                    fetch_addr = 16'($urandom);
                    r = int'(fetch_addr);
                    run_txn(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                            lat, 1'b1);
                    run_txn(1'b0, 1'b0, 16'(r), 16'h0000, 16'($urandom), lat2, 1'b0);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
